// File: rtl/fast_core_pkg.sv
// -----------------------------------------------------------------------------
// fast_core_pkg
// Shared constants and types for the fast_core front end.
//   - Fetch geometry: a fetch delivers FETCH_WAYS words of FETCH_WORD_BYTES
//     bytes each; an instruction is at most INSTR_MAX_BYTES bytes.
//   - MCS-51 opcode constants for the 3-byte instructions that are singled out
//     in the length decoder, plus the reserved opcode 0xA5.
// -----------------------------------------------------------------------------
package fast_core_pkg;

    localparam int INSTR_MAX_BYTES  = 3;
    localparam int FETCH_WORD_BYTES = 3;
    localparam int FETCH_WAYS       = 2;
    localparam int FETCH_BYTES      = FETCH_WAYS * FETCH_WORD_BYTES;

    typedef logic [7:0] byte_t;
    typedef logic [1:0] ilen_t;

    // 3-byte opcodes with an individual encoding
    localparam byte_t OP_LJMP        = 8'h02;
    localparam byte_t OP_LCALL       = 8'h12;
    localparam byte_t OP_JBC         = 8'h10;
    localparam byte_t OP_JB          = 8'h20;
    localparam byte_t OP_JNB         = 8'h30;
    localparam byte_t OP_ORL_DIR_IMM = 8'h43;
    localparam byte_t OP_ANL_DIR_IMM = 8'h53;
    localparam byte_t OP_XRL_DIR_IMM = 8'h63;
    localparam byte_t OP_MOV_DIR_IMM = 8'h75;
    localparam byte_t OP_MOV_DIR_DIR = 8'h85;
    localparam byte_t OP_MOV_DPTR    = 8'h90;
    localparam byte_t OP_DJNZ_DIR    = 8'hD5;
    // CJNE occupies the whole 0xB4..0xBF row
    localparam logic [3:0] OP_CJNE_ROW = 4'hB;
    // Reserved opcode, treated as a single byte
    localparam byte_t OP_RESERVED_A5 = 8'hA5;

endpackage : fast_core_pkg

// File: rtl/fast_core_inst_len.sv
// -----------------------------------------------------------------------------
// fast_core_inst_len
// Purely combinational MCS-51 instruction length decoder.
// Ports:
//   opcode  in  8  first byte of the instruction
//   length  out 2  instruction length in bytes, 1..3
// -----------------------------------------------------------------------------
module fast_core_inst_len
    import fast_core_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] length
);

    logic [3:0] hi_s;
    logic [3:0] lo_s;

    assign hi_s = opcode[7:4];
    assign lo_s = opcode[3:0];

    // Length lookup: explicit 3-byte/reserved opcodes first, then by column
    always_comb begin
        length = 2'd1;
        case (opcode)
            OP_LJMP, OP_LCALL, OP_JBC, OP_JB, OP_JNB,
            OP_ORL_DIR_IMM, OP_ANL_DIR_IMM, OP_XRL_DIR_IMM,
            OP_MOV_DIR_IMM, OP_MOV_DIR_DIR, OP_MOV_DPTR, OP_DJNZ_DIR: begin
                length = 2'd3;
            end
            OP_RESERVED_A5: begin
                length = 2'd1;
            end
            default: begin
                case (lo_s)
                    // relative jumps, bit ops with /bit, PUSH/POP
                    4'h0: length = (hi_s inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                                 4'hA, 4'hB, 4'hC, 4'hD}) ? 2'd2 : 2'd1;
                    // AJMP/ACALL in every row
                    4'h1: length = 2'd2;
                    // RET/RETI/MOVX are single byte, the rest are dir/bit forms
                    4'h2: length = (hi_s inside {4'h2, 4'h3, 4'hE, 4'hF}) ? 2'd1 : 2'd2;
                    // accumulator/carry ops (dir,#imm handled above)
                    4'h3: length = 2'd1;
                    // #imm forms and CJNE A,#imm,rel
                    4'h4: length = (hi_s == OP_CJNE_ROW) ? 2'd3 :
                                   (hi_s inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                                 4'h7, 4'h9}) ? 2'd2 : 2'd1;
                    // direct-address forms; CJNE A,dir,rel is 3 bytes
                    4'h5: length = (hi_s == OP_CJNE_ROW) ? 2'd3 : 2'd2;
                    // @Ri forms
                    4'h6, 4'h7: length = (hi_s == OP_CJNE_ROW) ? 2'd3 :
                                         (hi_s inside {4'h7, 4'h8, 4'hA}) ? 2'd2 : 2'd1;
                    // Rn forms, including DJNZ Rn,rel
                    default: length = (hi_s == OP_CJNE_ROW) ? 2'd3 :
                                      (hi_s inside {4'h7, 4'h8, 4'hA, 4'hD}) ? 2'd2 : 2'd1;
                endcase
            end
        endcase
    end

endmodule : fast_core_inst_len

// File: rtl/fast_core_i_align.sv
// -----------------------------------------------------------------------------
// fast_core_i_align
// Instruction alignment queue between the two-way fetch stage and decode.
// Fetched bytes are appended to a shift-down byte queue (head at q[0]); the
// head instruction is presented left-aligned and popped when decode consumes.
// Ports:
//   clk, reset_n (sync, active-low), sync_reset (sync flush, same as reset)
//   flush                          branch redirect, empties the queue
//   data_valid, data_B, data_A     fetched bytes PC..PC+2 (B), PC+3..PC+5 (A)
//   consume                        decode takes the presented instruction
//   ctl_fetch_instruction_request  room for a full 6-byte fetch
//   addr_adjust                    bytes popped this cycle
//   current_instruction            head bytes, [23:16] = opcode
//   instruction_length             length of head opcode (1..3)
//   instruction_valid              all bytes of the head instruction present
//   overflow                       sticky: data arrived while not requesting
// -----------------------------------------------------------------------------
module fast_core_i_align
    import fast_core_pkg::*;
#(
    parameter int QUEUE_BYTES    = 9,
    parameter int FILL_THRESHOLD = QUEUE_BYTES - 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_reset,
    input  logic        flush,
    input  logic        data_valid,
    input  logic [23:0] data_B,
    input  logic [23:0] data_A,
    input  logic        consume,
    output logic        ctl_fetch_instruction_request,
    output logic [1:0]  addr_adjust,
    output logic [23:0] current_instruction,
    output logic [1:0]  instruction_length,
    output logic        instruction_valid,
    output logic        overflow
);

    localparam logic [3:0] FILL_C        = 4'(FILL_THRESHOLD);
    localparam logic [3:0] FETCH_BYTES_C = 4'(FETCH_BYTES);

    byte_t       q_r [QUEUE_BYTES];
    logic [3:0]  count_r;
    logic        overflow_r;

    byte_t       q_next_s [QUEUE_BYTES];
    byte_t       fetch_s  [FETCH_BYTES];
    logic [3:0]  count_next_s;
    ilen_t       head_len_raw_s;
    ilen_t       len_s;
    logic        valid_s;
    logic        req_s;
    logic        hold_s;
    logic        pop_s;
    ilen_t       pop_len_s;
    logic        push_s;
    logic        drop_s;
    logic [3:0]  base_s;

    fast_core_inst_len u_inst_len (
        .opcode (q_r[0]),
        .length (head_len_raw_s)
    );

    // Fetched bytes in address order: B first, then A, MSB byte lowest address
    always_comb begin
        for (int k = 0; k < FETCH_WORD_BYTES; k++) begin
            fetch_s[k]                    = data_B[23 - 8*k -: 8];
            fetch_s[k + FETCH_WORD_BYTES] = data_A[23 - 8*k -: 8];
        end
    end

    // Head window: slots at or beyond the occupancy read as zero
    always_comb begin
        current_instruction = 24'h000000;
        for (int i = 0; i < INSTR_MAX_BYTES; i++) begin
            if (4'(i) < count_r) begin
                current_instruction[23 - 8*i -: 8] = q_r[i];
            end else begin
                current_instruction[23 - 8*i -: 8] = 8'h00;
            end
        end
    end

    assign len_s   = (count_r == 4'd0) ? 2'd1 : head_len_raw_s;
    assign valid_s = (count_r != 4'd0) && (count_r >= {2'b00, len_s});
    assign req_s   = (count_r <= FILL_C);

    // Reset, soft reset and flush all discard this cycle's pop and push
    assign hold_s    = !reset_n || sync_reset || flush;
    assign pop_s     = consume && valid_s && !hold_s;
    assign pop_len_s = pop_s ? len_s : 2'd0;
    assign push_s    = data_valid && req_s && !hold_s;
    assign drop_s    = data_valid && !req_s && !hold_s;

    // New bytes land right after what survives the pop
    assign base_s       = count_r - {2'b00, pop_len_s};
    assign count_next_s = base_s + (push_s ? FETCH_BYTES_C : 4'd0);

    // Next queue image: shift down by the popped length, then append the fetch
    always_comb begin
        int src_v;
        int off_v;
        for (int i = 0; i < QUEUE_BYTES; i++) begin
            src_v = i + int'(pop_len_s);
            off_v = i - int'(base_s);
            if (push_s && (off_v >= 0) && (off_v < FETCH_BYTES)) begin
                q_next_s[i] = fetch_s[off_v];
            end else if (src_v < QUEUE_BYTES) begin
                q_next_s[i] = q_r[src_v];
            end else begin
                q_next_s[i] = 8'h00;
            end
        end
    end

    // Queue, occupancy and sticky overflow state
    always_ff @(posedge clk) begin
        if (!reset_n || sync_reset) begin
            count_r    <= 4'd0;
            overflow_r <= 1'b0;
            for (int i = 0; i < QUEUE_BYTES; i++) begin
                q_r[i] <= 8'h00;
            end
        end else if (flush) begin
            count_r <= 4'd0;
        end else begin
            count_r    <= count_next_s;
            overflow_r <= overflow_r | drop_s;
            for (int i = 0; i < QUEUE_BYTES; i++) begin
                q_r[i] <= q_next_s[i];
            end
        end
    end

    assign ctl_fetch_instruction_request = req_s;
    assign addr_adjust                   = pop_len_s;
    assign instruction_length            = len_s;
    assign instruction_valid             = valid_s;
    assign overflow                      = overflow_r;

endmodule : fast_core_i_align

// File: tb/tb_fast_core_i_align.sv
// -----------------------------------------------------------------------------
// tb_fast_core_i_align
// Directed bench for fast_core_i_align. Each step drives inputs on the falling
// edge, queues the outputs expected for that cycle, and compares them 1 ns
// later against the head of the queue.
// -----------------------------------------------------------------------------
module tb_fast_core_i_align;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_reset;
    logic        flush;
    logic        data_valid;
    logic [23:0] data_B;
    logic [23:0] data_A;
    logic        consume;
    logic        ctl_fetch_instruction_request;
    logic [1:0]  addr_adjust;
    logic [23:0] current_instruction;
    logic [1:0]  instruction_length;
    logic        instruction_valid;
    logic        overflow;

    typedef struct packed {
        logic [23:0] ci;
        logic [1:0]  len;
        logic        valid;
        logic        req;
        logic [1:0]  adj;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fast_core_i_align dut (
        .clk                           (clk),
        .reset_n                       (reset_n),
        .sync_reset                    (sync_reset),
        .flush                         (flush),
        .data_valid                    (data_valid),
        .data_B                        (data_B),
        .data_A                        (data_A),
        .consume                       (consume),
        .ctl_fetch_instruction_request (ctl_fetch_instruction_request),
        .addr_adjust                   (addr_adjust),
        .current_instruction           (current_instruction),
        .instruction_length            (instruction_length),
        .instruction_valid             (instruction_valid),
        .overflow                      (overflow)
    );

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic dv, input logic [23:0] b, input logic [23:0] a,
                        input logic cons, input logic fl, input logic sr,
                        input logic [23:0] e_ci, input logic [1:0] e_len,
                        input logic e_val, input logic e_req,
                        input logic [1:0] e_adj, input logic e_ovf);
        exp_t e;
        @(negedge clk);
        data_valid = dv;
        data_B     = b;
        data_A     = a;
        consume    = cons;
        flush      = fl;
        sync_reset = sr;
        e.ci = e_ci; e.len = e_len; e.valid = e_val;
        e.req = e_req; e.adj = e_adj; e.ovf = e_ovf;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, "current_instruction", 32'(current_instruction), 32'(e.ci));
            chk(tag, "instruction_length",  32'(instruction_length),  32'(e.len));
            chk(tag, "instruction_valid",   32'(instruction_valid),   32'(e.valid));
            chk(tag, "request",             32'(ctl_fetch_instruction_request), 32'(e.req));
            chk(tag, "addr_adjust",         32'(addr_adjust),         32'(e.adj));
            chk(tag, "overflow",            32'(overflow),            32'(e.ovf));
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        sync_reset = 1'b0;
        flush      = 1'b0;
        data_valid = 1'b0;
        data_B     = 24'h000000;
        data_A     = 24'h000000;
        consume    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        //    tag           dv    B           A           cons  fl    sr    ci          len   val   req   adj   ovf
        step("reset",       1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0);
        step("push1",       1'b1, 24'h7401E4, 24'h021234, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0);
        step("head74",      1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h7401E4, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0);
        step("headE4",      1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'hE40212, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("ljmp3",       1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h021234, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0);
        step("empty_push",  1'b1, 24'h040404, 24'h049012, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0);
        step("pop04_a",     1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h040404, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("pop04_b",     1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h040404, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("pop04_c",     1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h040490, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("pop04_d",     1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h049012, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0);
        step("dptr_short",  1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h901200, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0);
        step("dptr_push",   1'b1, 24'h34E4E4, 24'h745500, 1'b0, 1'b0, 1'b0, 24'h901200, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0);
        step("dptr_full",   1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'h901234, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0);
        step("clrA_a",      1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'hE4E474, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("clrA_b",      1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'hE47455, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
        step("pop_push",    1'b1, 24'hB41122, 24'h334455, 1'b1, 1'b0, 1'b0, 24'h745500, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0);
        step("cnt7_drop",   1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 24'h00B411, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0);
        step("ovf_pop",     1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 24'h00B411, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1);
        step("cjne",        1'b0, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b0, 24'hB41122, 2'd3, 1'b1, 1'b0, 2'd3, 1'b1);
        step("srst",        1'b1, 24'h123456, 24'h789ABC, 1'b1, 1'b0, 1'b1, 24'h334455, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1);
        step("post_srst",   1'b1, 24'h7401E4, 24'h021234, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0);
        step("flush",       1'b1, 24'hAAAAAA, 24'h555555, 1'b1, 1'b1, 1'b0, 24'h7401E4, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0);
        step("post_flush",  1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd1, 1'b0, 1'b1, 2'd0, 1'b0);

        @(negedge clk);
        data_valid = 1'b0;
        consume    = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fast_core_i_align
